// File: rtl/qpll_reset_ctrl.sv
// qpll_reset_ctrl: power-up / reset / lock-qualification sequencer for one
// quad QPLL. Drives QPLLPD and QPLLRESET, synchronizes the asynchronous lock
// and refclk-lost flags, retries failed bring-ups and reports a qualified
// qpll_ready_o to the per-channel reset sequencers.
// Optional macro QPLL_RESET_CTRL_AUTORECOVER_EN: lock loss while LOCKED
// re-sequences from PD instead of entering the sticky FAULT state.
module qpll_reset_ctrl #(
    parameter int PD_CYCLES           = 16,
    parameter int RESET_CYCLES        = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_FILTER_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             qplllock_i,
    input  logic             qpllrefclklost_i,
    output logic             qpllpd_o,
    output logic             qpllreset_o,
    output logic             qpll_ready_o,
    output logic             qpll_fault_o,
    output logic [RTY_W-1:0] retry_cnt_o,
    output logic [2:0]       state_o
);

    localparam int PD_W  = $clog2(PD_CYCLES) + 1;
    localparam int RST_W = $clog2(RESET_CYCLES) + 1;
    localparam int SEQ_W = (PD_W > RST_W) ? PD_W : RST_W;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int FLT_W = $clog2(LOCK_FILTER_CYCLES) + 1;

    localparam logic [SEQ_W-1:0] PD_LAST  = SEQ_W'(PD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] RST_LAST = SEQ_W'(RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PD     = 3'd1,
        S_RST    = 3'd2,
        S_WAIT   = 3'd3,
        S_FILT   = 3'd4,
        S_LOCKED = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;   // PD / RST phase length
    logic [TO_W-1:0]    to_q, to_d;     // lock timeout across WAIT+FILTER
    logic [FLT_W-1:0]   flt_q, flt_d;   // consecutive locked cycles in FILTER
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic               lock_meta_q, lock_s_q;
    logic               lost_meta_q, lost_s_q;
    logic               do_retry;

    // Two-flop synchronizers for the asynchronous QPLL status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lost_meta_q <= 1'b0;
            lost_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= qplllock_i;
            lock_s_q    <= lock_meta_q;
            lost_meta_q <= qpllrefclklost_i;
            lost_s_q    <= lost_meta_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            to_q    <= '0;
            flt_q   <= '0;
            rty_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            to_q    <= to_d;
            flt_q   <= flt_d;
            rty_q   <= rty_d;
        end
    end

    // Next-state logic: enable_i low overrides everything; counters saturate
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        to_d     = to_q;
        flt_d    = flt_q;
        rty_d    = rty_q;
        do_retry = 1'b0;

        if (!enable_i) begin
            state_d = S_IDLE;
            seq_d   = '0;
            to_d    = '0;
            flt_d   = '0;
            rty_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PD;
                    seq_d   = '0;
                end
                S_PD: begin
                    if (seq_q == PD_LAST) begin
                        state_d = S_RST;
                        seq_d   = '0;
                    end else if (!(&seq_q)) begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end
                S_RST: begin
                    to_d = '0;
                    if (seq_q == RST_LAST) begin
                        state_d = S_WAIT;
                        seq_d   = '0;
                    end else if (!(&seq_q)) begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!(&to_q)) to_d = to_q + TO_W'(1);
                    if (lost_s_q || to_q == TO_LAST) begin
                        do_retry = 1'b1;
                    end else if (lock_s_q) begin
                        state_d = S_FILT;
                        flt_d   = '0;
                    end
                end
                S_FILT: begin
                    if (!(&to_q)) to_d = to_q + TO_W'(1);
                    // refclk loss invalidates any lock; a completed filter
                    // beats a simultaneous timeout
                    if (lost_s_q) begin
                        do_retry = 1'b1;
                    end else if (lock_s_q && flt_q == FLT_LAST) begin
                        state_d = S_LOCKED;
                    end else if (to_q == TO_LAST) begin
                        do_retry = 1'b1;
                    end else if (!lock_s_q) begin
                        state_d = S_WAIT;
                    end else if (!(&flt_q)) begin
                        flt_d = flt_q + FLT_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (!lock_s_q || lost_s_q) begin
`ifdef QPLL_RESET_CTRL_AUTORECOVER_EN
                        state_d = S_PD;
                        seq_d   = '0;
                        rty_d   = '0;
`else
                        state_d = S_FAULT;
`endif
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase

            if (do_retry) begin
                if (rty_q < RTY_MAX) begin
                    rty_d   = rty_q + RTY_W'(1);
                    state_d = S_PD;
                    seq_d   = '0;
                end else begin
                    state_d = S_FAULT;
                end
            end
        end
    end

    // Moore output decodes
    always_comb begin
        qpllpd_o     = (state_q == S_IDLE) || (state_q == S_PD) || (state_q == S_FAULT);
        qpllreset_o  = qpllpd_o || (state_q == S_RST);
        qpll_ready_o = (state_q == S_LOCKED);
        qpll_fault_o = (state_q == S_FAULT);
        retry_cnt_o  = rty_q;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_qpll_reset_ctrl.sv
// Directed bench for qpll_reset_ctrl with PD=4, RST=8, TIMEOUT=100,
// FILTER=16, MAX_RETRIES=2. Inputs change 1 ns after a rising edge and
// outputs are checked at that same point.
module tb_qpll_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, enable_i, qplllock_i, qpllrefclklost_i;
    logic       qpllpd_o, qpllreset_o, qpll_ready_o, qpll_fault_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    qpll_reset_ctrl #(
        .PD_CYCLES(4), .RESET_CYCLES(8), .LOCK_TIMEOUT_CYCLES(100),
        .LOCK_FILTER_CYCLES(16), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .qplllock_i(qplllock_i), .qpllrefclklost_i(qpllrefclklost_i),
        .qpllpd_o(qpllpd_o), .qpllreset_o(qpllreset_o),
        .qpll_ready_o(qpll_ready_o), .qpll_fault_o(qpll_fault_o),
        .retry_cnt_o(retry_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic pd,
                              input logic rs, input logic rdy, input logic flt,
                              input logic [1:0] rty);
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_pd"}, 32'(qpllpd_o), 32'(pd));
        check({tag, "_rst"}, 32'(qpllreset_o), 32'(rs));
        check({tag, "_ready"}, 32'(qpll_ready_o), 32'(rdy));
        check({tag, "_fault"}, 32'(qpll_fault_o), 32'(flt));
        check({tag, "_retry"}, 32'(retry_cnt_o), 32'(rty));
    endtask

    initial begin
        int  cyc;
        int  falls;
        logic prev_rst;
        logic saw_ready;

        rst_n = 1'b0; enable_i = 1'b0; qplllock_i = 1'b0; qpllrefclklost_i = 1'b0;
        step(2);
        check_outs("reset", 3'd0, 1, 1, 0, 0, 2'd0);
        rst_n = 1'b1;
        step(1);
        check_outs("idle_hold", 3'd0, 1, 1, 0, 0, 2'd0);

        // Nominal bring-up
        enable_i = 1'b1;
        step(1);  check_outs("nom_pd0", 3'd1, 1, 1, 0, 0, 2'd0);
        step(3);  check_outs("nom_pd3", 3'd1, 1, 1, 0, 0, 2'd0);
        step(1);  check_outs("nom_rst0", 3'd2, 0, 1, 0, 0, 2'd0);
        step(7);  check_outs("nom_rst7", 3'd2, 0, 1, 0, 0, 2'd0);
        step(1);  check_outs("nom_wait0", 3'd3, 0, 0, 0, 0, 2'd0);
        step(9);  check("nom_wait9", 32'(state_o), 32'd3);
        qplllock_i = 1'b1;
        step(18); check_outs("nom_filt", 3'd4, 0, 0, 0, 0, 2'd0);
        step(1);  check_outs("nom_locked", 3'd5, 0, 0, 1, 0, 2'd0);

        // Lock loss while LOCKED
        qplllock_i = 1'b0;
        step(2);  check("ll_still_ready", 32'(qpll_ready_o), 32'd1);
        step(1);
`ifdef QPLL_RESET_CTRL_AUTORECOVER_EN
        check_outs("ll_pd", 3'd1, 1, 1, 0, 0, 2'd0);
        qplllock_i = 1'b1;
        step(28); check("ll_relock_pre", 32'(qpll_ready_o), 32'd0);
        step(1);  check_outs("ll_relock", 3'd5, 0, 0, 1, 0, 2'd0);
`else
        check_outs("ll_fault", 3'd6, 1, 1, 0, 1, 2'd0);
        step(5);  check_outs("ll_sticky", 3'd6, 1, 1, 0, 1, 2'd0);
`endif
        enable_i = 1'b0; qplllock_i = 1'b0;
        step(1);  check_outs("ll_idle", 3'd0, 1, 1, 0, 0, 2'd0);
        step(3);

        // Mid-sequence abort during RST
        enable_i = 1'b1;
        step(1);  check("ab_pd", 32'(state_o), 32'd1);
        step(4);  check("ab_rst", 32'(state_o), 32'd2);
        enable_i = 1'b0;
        step(1);  check_outs("ab_idle", 3'd0, 1, 1, 0, 0, 2'd0);

        // No lock: three bring-up attempts, then FAULT
        enable_i = 1'b1;
        prev_rst = qpllreset_o; cyc = 0; falls = 0; saw_ready = 1'b0;
        while (state_o != 3'd6 && cyc < 400) begin
            step(1);
            cyc++;
            if (prev_rst && !qpllreset_o) falls++;
            prev_rst = qpllreset_o;
            if (qpll_ready_o) saw_ready = 1'b1;
        end
        check("nl_cycles", 32'(cyc), 32'd337);
        check("nl_rst_pulses", 32'(falls), 32'd3);
        check("nl_no_ready", 32'(saw_ready), 32'd0);
        check_outs("nl_fault", 3'd6, 1, 1, 0, 1, 2'd2);
        enable_i = 1'b0;
        step(1);  check_outs("nl_idle", 3'd0, 1, 1, 0, 0, 2'd0);

        // One-cycle lock glitch inside FILTER
        enable_i = 1'b1;
        step(1);
        step(12); check("gl_wait", 32'(state_o), 32'd3);
        qplllock_i = 1'b1;
        step(10); check("gl_filt", 32'(state_o), 32'd4);
        qplllock_i = 1'b0;
        step(1);
        qplllock_i = 1'b1;
        step(2);  check("gl_back_wait", 32'(state_o), 32'd3);
        check("gl_retry", 32'(retry_cnt_o), 32'd0);
        step(1);  check("gl_refilt", 32'(state_o), 32'd4);
        step(15); check_outs("gl_pre", 3'd4, 0, 0, 0, 0, 2'd0);
        step(1);  check_outs("gl_locked", 3'd5, 0, 0, 1, 0, 2'd0);

        // Reset while LOCKED
        rst_n = 1'b0;
        step(1);  check_outs("rl_reset", 3'd0, 1, 1, 0, 0, 2'd0);

        // Refclk lost in WAIT_LOCK
        qplllock_i = 1'b0;
        rst_n = 1'b1;
        step(1);  check("rc_pd", 32'(state_o), 32'd1);
        step(12); check("rc_wait", 32'(state_o), 32'd3);
        step(5);
        qpllrefclklost_i = 1'b1;
        step(2);  check("rc_still_wait", 32'(state_o), 32'd3);
        step(1);  check_outs("rc_retry", 3'd1, 1, 1, 0, 0, 2'd1);
        qpllrefclklost_i = 1'b0;
        step(4);  check("rc_rst", 32'(state_o), 32'd2);
        enable_i = 1'b0;
        step(1);  check_outs("rc_idle", 3'd0, 1, 1, 0, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
